ts_uart_msg_seq: RTL and testbench
==================================

Name: ts_uart_msg_seq

Overview:
Sequencer between the timestamp source and the byte-wide UART transmitter. On a trigger, it snapshots a binary value and emits it as uppercase ASCII hex, MSB nibble first, followed by CR and LF. Bytes go out one at a time over a valid/ready handshake. A trigger comes either from an external start pulse or from an internal free-running period counter, so the value is reported on the serial line forever.

Parameters:
C_NIBBLES, 8, number of hex digits sent; DAT_i width is 4*C_NIBBLES; legal range 1..16
C_PERIOD, 48_000_000, auto-trigger period in CK_i cycles; must be >= 2
C_AUTO, 1, 1 = period counter generates triggers; 0 = only START_i triggers

Ports:
CK_i  in  1  system clock; all state on rising edge
XARST_i  in  1  asynchronous active-low reset
START_i  in  1  one-cycle trigger request
DAT_i  in  4*C_NIBBLES  value to report; sampled only at trigger acceptance
TX_RDY_i  in  1  UART transmitter can accept a byte this cycle
TX_DAT_o  out  8  ASCII byte offered to the UART
TX_VAL_o  out  1  TX_DAT_o is valid
BUSY_o  out  1  a message is in progress
DONE_o  out  1  one-cycle pulse after the LF byte is accepted
OVR_o  out  1  sticky flag: a trigger was dropped because a message was in progress
CLR_OVR_i  in  1  clears OVR_o

Behaviour:
- Reset (XARST_i=0, asynchronous): state IDLE, period counter 0, shift register 0. All outputs 0: TX_DAT_o=0x00, TX_VAL_o, BUSY_o, DONE_o, OVR_o. Reset mid-message aborts immediately; no byte is resent after release.
- Period counter: counts 0..C_PERIOD-1 and wraps. tick=1 in the cycle where count==C_PERIOD-1. Counter is free-running regardless of state. Width is ceil(log2(C_PERIOD)).
- trig = START_i | (C_AUTO & tick). START_i and tick in the same cycle give a single trigger.
- States:
  - IDLE: trig -> latch DAT_i into the shift register, nibble index=0, go to HEX.
  - HEX: TX_VAL_o=1, TX_DAT_o=ascii(top nibble). On accept (TX_VAL_o&TX_RDY_i), shift left 4 bits. After the C_NIBBLES-th accept, go to CR.
  - CR: TX_DAT_o=0x0D. On accept, go to LF.
  - LF: TX_DAT_o=0x0A. On accept, go to IDLE and assert DONE_o for exactly the next cycle.
- ascii(n): 0..9 -> 0x30..0x39; 10..15 -> 0x41..0x46.
- TX_DAT_o and TX_VAL_o are registered.
  - Latency: trigger at edge k gives TX_VAL_o=1 with the first digit from cycle k+1.
  - With TX_RDY_i held high, the C_NIBBLES+2 bytes go out on consecutive cycles.
- Handshake:
  - TX_DAT_o is stable while TX_VAL_o=1 and TX_RDY_i=0.
  - TX_VAL_o never drops without an accept, except on reset.
  - TX_RDY_i with TX_VAL_o=0 has no effect.
- BUSY_o=1 in HEX, CR and LF; BUSY_o=0 in IDLE, including the DONE_o cycle.
- Trigger acceptance:
  - A trigger in the DONE_o cycle is accepted normally (back-to-back messages).
  - A trigger while BUSY_o=1, including the cycle the LF is accepted, is dropped: DAT_i is not sampled and OVR_o is set on the next edge.
  - A dropped trigger is not queued.
- OVR_o: set has priority over CLR_OVR_i in the same cycle; CLR_OVR_i alone clears it on the next edge.
- DAT_i changes after the snapshot have no effect on the message in progress.

Test Plan:
1. C_AUTO=0, C_NIBBLES=8, TX_RDY_i=1, DAT_i=0x1234ABCF, START_i pulse at cycle 10 -> TX_DAT_o 0x31,32,33,34,41,42,43,46,0D,0A valid cycles 11..20. DONE_o=1 at cycle 21 only. BUSY_o=1 cycles 11..20. OVR_o=0.
2. Same message with TX_RDY_i toggling 1-0-0-1 pseudo-randomly -> identical 10-byte sequence. TX_DAT_o never changes while TX_VAL_o=1 and TX_RDY_i=0. DONE_o exactly once.
3. START_i at cycle 10, second START_i at cycle 15 with TX_RDY_i=1 -> only one message; OVR_o=1 from cycle 16. CLR_OVR_i at cycle 30 -> OVR_o=0 at 31. Set+clear in the same cycle -> OVR_o stays 1.
4. C_AUTO=1, C_PERIOD=100, C_NIBBLES=2, TX_RDY_i=1, DAT_i=0x0F -> message 0x30,0x46,0x0D,0x0A starting cycles 100, 200, 300 after reset release. OVR_o stays 0. START_i coincident with tick -> one message, no OVR.
5. Back-to-back: START_i asserted in the DONE_o cycle -> next message's first byte valid on the following cycle, no OVR.
6. XARST_i pulsed low after the 3rd byte is accepted -> all outputs 0 immediately. After release, no TX_VAL_o until the next trigger; the next message starts from the top digit.

Source files
------------

// File: rtl/ts_uart_msg_seq.sv
// Timestamp-to-UART message sequencer: on each trigger, snapshots DAT_i and sends it as
// uppercase ASCII hex (MSB nibble first) followed by CR LF over a valid/ready byte handshake.
module ts_uart_msg_seq #(
  parameter int C_NIBBLES = 8,
  parameter int C_PERIOD  = 48_000_000,
  parameter bit C_AUTO    = 1'b1
) (
  input  logic                   CK_i,
  input  logic                   XARST_i,
  input  logic                   START_i,
  input  logic [4*C_NIBBLES-1:0] DAT_i,
  input  logic                   TX_RDY_i,
  output logic [7:0]             TX_DAT_o,
  output logic                   TX_VAL_o,
  output logic                   BUSY_o,
  output logic                   DONE_o,
  output logic                   OVR_o,
  input  logic                   CLR_OVR_i
);

  localparam int W  = 4 * C_NIBBLES;
  localparam int CW = (C_PERIOD > 1) ? $clog2(C_PERIOD) : 1;
  localparam int NW = $clog2(C_NIBBLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(C_PERIOD - 1);
  localparam logic [NW-1:0] NIB_LAST = NW'(C_NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HEX, S_CR, S_LF} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    sh_q, sh_d, sh_shift;
  logic [NW-1:0]   nib_q, nib_d;
  logic [7:0]      tx_dat_q, tx_dat_d;
  logic            tx_val_q, tx_val_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic            tick, trig, accept, busy;

  function automatic logic [7:0] ascii(input logic [3:0] n);
    ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign tick     = (cnt_q == CNT_LAST);
  assign trig     = START_i | (C_AUTO & tick);
  assign accept   = tx_val_q & TX_RDY_i;
  assign busy     = (state_q != S_IDLE);
  assign sh_shift = sh_q << 4;
  assign cnt_d    = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      nib_q    <= '0;
      tx_dat_q <= 8'h00;
      tx_val_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      nib_q    <= nib_d;
      tx_dat_q <= tx_dat_d;
      tx_val_q <= tx_val_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    nib_d   = nib_q;
    unique case (state_q)
      S_IDLE: if (trig) begin
        sh_d    = DAT_i;
        nib_d   = '0;
        state_d = S_HEX;
      end
      S_HEX: if (accept) begin
        sh_d  = sh_shift;
        nib_d = nib_q + 1'b1;
        if (nib_q == NIB_LAST) state_d = S_CR;
      end
      S_CR: if (accept) state_d = S_LF;
      S_LF: if (accept) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so the byte for the next state is prepared here.
  always_comb begin
    tx_val_d = tx_val_q;
    tx_dat_d = tx_dat_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: if (trig) begin
        tx_val_d = 1'b1;
        tx_dat_d = ascii(DAT_i[W-1 -: 4]);
      end
      S_HEX: if (accept) tx_dat_d = (nib_q == NIB_LAST) ? 8'h0D : ascii(sh_shift[W-1 -: 4]);
      S_CR:  if (accept) tx_dat_d = 8'h0A;
      S_LF: if (accept) begin
        tx_val_d = 1'b0;
        tx_dat_d = 8'h00;
        done_d   = 1'b1;
      end
      default: begin
        tx_val_d = 1'b0;
        tx_dat_d = 8'h00;
      end
    endcase
    // A dropped trigger wins over a clear in the same cycle.
    if (trig && busy)   ovr_d = 1'b1;
    else if (CLR_OVR_i) ovr_d = 1'b0;
    else                ovr_d = ovr_q;
  end

  assign TX_DAT_o = tx_dat_q;
  assign TX_VAL_o = tx_val_q;
  assign BUSY_o   = busy;
  assign DONE_o   = done_q;
  assign OVR_o    = ovr_q;

endmodule

// File: tb/tb_ts_uart_msg_seq.sv
// Scoreboard bench for ts_uart_msg_seq: a manually triggered 8-digit instance and an
// auto-triggered 2-digit instance, each with its own expected-byte queue and monitor.
module tb_ts_uart_msg_seq;

  typedef struct {logic [7:0] b; int cyc;} exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Manual instance
  logic        rst_m_n = 1'b0, start_m = 1'b0, rdy_m = 1'b1, clr_m = 1'b0;
  logic [31:0] din_m = 32'h1234_ABCF;
  logic [7:0]  dat_m;
  logic        val_m, busy_m, done_m, ovr_m;
  // Auto instance
  logic        rst_a_n = 1'b0, start_a = 1'b0, rdy_a = 1'b1, clr_a = 1'b0;
  logic [7:0]  din_a = 8'h0F;
  logic [7:0]  dat_a;
  logic        val_a, busy_a, done_a, ovr_a;

  ts_uart_msg_seq #(.C_NIBBLES(8), .C_PERIOD(1000), .C_AUTO(1'b0)) u_man (
    .CK_i(clk), .XARST_i(rst_m_n), .START_i(start_m), .DAT_i(din_m), .TX_RDY_i(rdy_m),
    .TX_DAT_o(dat_m), .TX_VAL_o(val_m), .BUSY_o(busy_m), .DONE_o(done_m), .OVR_o(ovr_m),
    .CLR_OVR_i(clr_m));

  ts_uart_msg_seq #(.C_NIBBLES(2), .C_PERIOD(100), .C_AUTO(1'b1)) u_auto (
    .CK_i(clk), .XARST_i(rst_a_n), .START_i(start_a), .DAT_i(din_a), .TX_RDY_i(rdy_a),
    .TX_DAT_o(dat_a), .TX_VAL_o(val_a), .BUSY_o(busy_a), .DONE_o(done_a), .OVR_o(ovr_a),
    .CLR_OVR_i(clr_a));

  int total = 0;
  int bad   = 0;
  int cyc_m = 0, cyc_a = 0;
  int done_cnt_m = 0, done_cnt_a = 0;
  exp_t q_m[$];
  exp_t q_a[$];
  logic hold_m = 1'b0, hold_a = 1'b0;
  logic [7:0] last_m = 8'h00, last_a = 8'h00;

  // Hand-computed messages: hex digits then CR LF.
  localparam logic [79:0] MSG_1234ABCF = 80'h31_32_33_34_41_42_43_46_0D_0A;
  localparam logic [79:0] MSG_0009FA5E = 80'h30_30_30_39_46_41_35_45_0D_0A;
  localparam logic [79:0] MSG_DEADBEEF = 80'h44_45_41_44_42_45_45_46_0D_0A;
  localparam logic [31:0] MSG_0F       = 32'h30_46_0D_0A;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_m(input logic [79:0] msg, input int nbytes, input int first);
    for (int i = 0; i < nbytes; i++) begin
      exp_t e;
      e.b   = msg[79-8*i -: 8];
      e.cyc = (first < 0) ? -1 : first + i;
      q_m.push_back(e);
    end
  endtask

  task automatic push_a(input int first);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.b   = MSG_0F[31-8*i -: 8];
      e.cyc = first + i;
      q_a.push_back(e);
    end
  endtask

  task automatic goto_m(input int n);
    while (cyc_m < n) begin @(posedge clk); #1; end
  endtask

  task automatic goto_a(input int n);
    while (cyc_a < n) begin @(posedge clk); #1; end
  endtask

  always @(posedge clk or negedge rst_m_n)
    if (!rst_m_n) cyc_m <= 0; else cyc_m <= cyc_m + 1;
  always @(posedge clk or negedge rst_a_n)
    if (!rst_a_n) cyc_a <= 0; else cyc_a <= cyc_a + 1;

  // Monitors sample on the falling edge; val&rdy there means accept at the next rising edge.
  always @(negedge clk) begin
    if (rst_m_n) begin
      if (hold_m) begin
        chk("hold_val_m", {31'd0, val_m}, 32'd1);
        chk("hold_dat_m", {24'd0, dat_m}, {24'd0, last_m});
      end
      if (val_m && rdy_m) begin
        if (q_m.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_byte_m: got %02h at cyc %0d want no byte", dat_m, cyc_m);
        end else begin
          $display("man  byte cyc=%0d dat=%02h exp=%02h", cyc_m, dat_m, q_m[0].b);
          chk("byte_m", {24'd0, dat_m}, {24'd0, q_m[0].b});
          if (q_m[0].cyc >= 0) chk("cyc_m", cyc_m, q_m[0].cyc);
          void'(q_m.pop_front());
        end
      end
      if (done_m) done_cnt_m <= done_cnt_m + 1;
      hold_m <= val_m && !rdy_m;
      last_m <= dat_m;
    end else begin
      hold_m <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_a_n) begin
      if (hold_a) begin
        chk("hold_val_a", {31'd0, val_a}, 32'd1);
        chk("hold_dat_a", {24'd0, dat_a}, {24'd0, last_a});
      end
      if (val_a && rdy_a) begin
        if (q_a.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_byte_a: got %02h at cyc %0d want no byte", dat_a, cyc_a);
        end else begin
          $display("auto byte cyc=%0d dat=%02h exp=%02h", cyc_a, dat_a, q_a[0].b);
          chk("byte_a", {24'd0, dat_a}, {24'd0, q_a[0].b});
          chk("cyc_a", cyc_a, q_a[0].cyc);
          void'(q_a.pop_front());
        end
      end
      if (done_a) done_cnt_a <= done_cnt_a + 1;
      hold_a <= val_a && !rdy_a;
      last_a <= dat_a;
    end else begin
      hold_a <= 1'b0;
    end
  end

  task automatic chk_zero_m(input string tag);
    chk({tag, "_dat"}, {24'd0, dat_m}, 32'd0);
    chk({tag, "_val"}, {31'd0, val_m}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_m}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_m}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, ovr_m}, 32'd0);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_dat"}, {24'd0, dat_a}, 32'd0);
    chk({tag, "_val"}, {31'd0, val_a}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, ovr_a}, 32'd0);
  endtask

  task automatic run_manual();
    int dc0;
    logic [31:0] pat;
    // Basic message with latency and flag timing
    goto_m(10); start_m = 1'b1; push_m(MSG_1234ABCF, 10, 11);
    chk("t1_val_before", {31'd0, val_m}, 32'd0);
    goto_m(11); start_m = 1'b0;
    chk("t1_val_first", {31'd0, val_m}, 32'd1);
    chk("t1_busy_first", {31'd0, busy_m}, 32'd1);
    goto_m(12); din_m = 32'hFFFF_FFFF;
    goto_m(20); chk("t1_busy_last", {31'd0, busy_m}, 32'd1);
    goto_m(21);
    chk("t1_done", {31'd0, done_m}, 32'd1);
    chk("t1_busy_done", {31'd0, busy_m}, 32'd0);
    chk("t1_val_done", {31'd0, val_m}, 32'd0);
    goto_m(22);
    chk("t1_done_off", {31'd0, done_m}, 32'd0);
    chk("t1_ovr", {31'd0, ovr_m}, 32'd0);

    // Same message under backpressure
    din_m = 32'h1234_ABCF; dc0 = done_cnt_m; pat = 32'b1001_0110_1100_1011_1001_1101_0110_1011;
    goto_m(30); start_m = 1'b1; push_m(MSG_1234ABCF, 10, -1);
    goto_m(31); start_m = 1'b0;
    for (int i = 0; i < 32; i++) begin rdy_m = pat[i]; @(posedge clk); #1; end
    rdy_m = 1'b1;
    for (int i = 0; i < 50 && done_cnt_m == dc0; i++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    chk("t2_done_once", done_cnt_m, dc0 + 1);

    // Dropped trigger sets OVR; clear; no queued message
    goto_m(70); start_m = 1'b1; push_m(MSG_1234ABCF, 10, 71);
    goto_m(71); start_m = 1'b0;
    goto_m(75); start_m = 1'b1; din_m = 32'h5555_5555;
    chk("t3_ovr_pre", {31'd0, ovr_m}, 32'd0);
    goto_m(76); start_m = 1'b0; din_m = 32'h1234_ABCF;
    chk("t3_ovr_set", {31'd0, ovr_m}, 32'd1);
    goto_m(82);
    chk("t3_ovr_hold", {31'd0, ovr_m}, 32'd1);
    chk("t3_no_queue", {31'd0, val_m}, 32'd0);
    goto_m(90); clr_m = 1'b1;
    goto_m(91); clr_m = 1'b0;
    chk("t3_ovr_clr", {31'd0, ovr_m}, 32'd0);
    goto_m(100); start_m = 1'b1; push_m(MSG_1234ABCF, 10, 101);
    goto_m(101); start_m = 1'b0;
    goto_m(105); start_m = 1'b1; clr_m = 1'b1;
    goto_m(106); start_m = 1'b0; clr_m = 1'b0;
    chk("t3_set_beats_clr", {31'd0, ovr_m}, 32'd1);
    goto_m(107); clr_m = 1'b1;
    goto_m(108); clr_m = 1'b0;
    chk("t3_ovr_clr2", {31'd0, ovr_m}, 32'd0);
    goto_m(110); start_m = 1'b1;
    goto_m(111); start_m = 1'b0;
    chk("t3_ovr_lf_cycle", {31'd0, ovr_m}, 32'd1);
    chk("t3_done_lf", {31'd0, done_m}, 32'd1);
    goto_m(112); chk("t3_no_msg_after_lf", {31'd0, val_m}, 32'd0);
    goto_m(115); clr_m = 1'b1;
    goto_m(116); clr_m = 1'b0;
    chk("t3_ovr_clr3", {31'd0, ovr_m}, 32'd0);

    // Back-to-back via trigger in the DONE cycle
    goto_m(120); start_m = 1'b1; push_m(MSG_1234ABCF, 10, 121);
    goto_m(121); start_m = 1'b0;
    goto_m(131);
    chk("t5_done1", {31'd0, done_m}, 32'd1);
    start_m = 1'b1; din_m = 32'h0009_FA5E; push_m(MSG_0009FA5E, 10, 132);
    goto_m(132); start_m = 1'b0;
    chk("t5_busy2", {31'd0, busy_m}, 32'd1);
    goto_m(142); chk("t5_done2", {31'd0, done_m}, 32'd1);
    goto_m(143); chk("t5_ovr", {31'd0, ovr_m}, 32'd0);

    // Reset mid-message after the 3rd byte is accepted
    goto_m(150); start_m = 1'b1; din_m = 32'hDEAD_BEEF; push_m(MSG_DEADBEEF, 3, 151);
    goto_m(151); start_m = 1'b0;
    goto_m(152); start_m = 1'b1;
    goto_m(153); start_m = 1'b0;
    chk("t6_ovr_before_rst", {31'd0, ovr_m}, 32'd1);
    goto_m(154); rst_m_n = 1'b0;
    #1; chk_zero_m("t6_rst");
    @(posedge clk); @(posedge clk); #1; rst_m_n = 1'b1;
    goto_m(20);
    chk("t6_idle_val", {31'd0, val_m}, 32'd0);
    chk("t6_idle_busy", {31'd0, busy_m}, 32'd0);
    goto_m(25); start_m = 1'b1; push_m(MSG_DEADBEEF, 10, 26);
    goto_m(26); start_m = 1'b0;
    goto_m(36); chk("t6_done", {31'd0, done_m}, 32'd1);
    goto_m(40);
  endtask

  task automatic run_auto();
    push_a(100); push_a(200); push_a(300);
    goto_a(99);  chk("t4_val_pre", {31'd0, val_a}, 32'd0);
    goto_a(100); chk("t4_busy_first", {31'd0, busy_a}, 32'd1);
    goto_a(299); start_a = 1'b1;
    goto_a(300); start_a = 1'b0;
    goto_a(350);
    chk("t4_ovr", {31'd0, ovr_a}, 32'd0);
    chk("t4_done_cnt", done_cnt_a, 3);
    rst_a_n = 1'b0;
    #1; chk_zero_a("t4_rst");
  endtask

  initial begin
    @(posedge clk); #1;
    chk_zero_m("rst_m");
    chk_zero_a("rst_a");
    @(posedge clk); #1;
    rst_m_n = 1'b1; rst_a_n = 1'b1;
    fork
      run_manual();
      run_auto();
    join
    @(posedge clk); #1;
    chk("queue_m_empty", q_m.size(), 0);
    chk("queue_a_empty", q_a.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
